bram_rr_arbiter: RTL and testbench

- Shares one single-port BRAM between NUM_PORTS requesters. Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin with at most one BRAM access per cycle. Per-port response buffering absorbs the 1-cycle BRAM read latency and any response backpressure.
- Sits between several BRAM-style clients (e.g. AXI-lite BRAM controllers, DMA engines) and one BRAM macro port.

---
 rtl/bram_rr_arbiter_if.sv | 28 ++
 rtl/bram_rr_arbiter.sv | 86 ++++++++
 tb/tb_bram_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_rr_arbiter_if.sv
// Client-side request/response bundle for the shared-BRAM round-robin arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface bram_rr_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS*STRB_WIDTH-1:0] req_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wrdata;
    logic [NUM_PORTS-1:0]            resp_valid;
    logic [NUM_PORTS-1:0]            resp_ready;
    logic [NUM_PORTS*DATA_WIDTH-1:0] resp_rddata;

    modport master (
        output req_valid, req_we, req_addr, req_wrdata, resp_ready,
        input  req_ready, resp_valid, resp_rddata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wrdata, resp_ready,
        output req_ready, resp_valid, resp_rddata
    );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between NUM_PORTS requesters,
// with one response slot per port that absorbs read latency and backpressure.
module bram_rr_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    bram_rr_arbiter_if.slave      bus,
    output logic                  bram_en,
    output logic [STRB_WIDTH-1:0] bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wrdata,
    input  logic [DATA_WIDTH-1:0] bram_rddata
);
    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]  resp_valid_q, resp_valid_d;
    logic [NUM_PORTS-1:0]  latched_q, latched_d, latch_load;
    logic [DATA_WIDTH-1:0] latch_data_q [NUM_PORTS];
    logic [PTR_W-1:0]      last_q;

    logic [NUM_PORTS-1:0]  eligible, grant;
    logic                  found;
    logic [PTR_W-1:0]      gidx;
    int unsigned           idx;

    // A slot being drained this cycle counts as free.
    always_comb begin
        eligible = bus.req_valid & (~resp_valid_q | bus.resp_ready);
        grant    = '0;
        found    = 1'b0;
        gidx     = '0;
        idx      = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = (32'(last_q) + k) % NUM_PORTS;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                gidx  = PTR_W'(idx);
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    assign bram_en     = found;
    assign bram_we     = found ? bus.req_we[gidx*STRB_WIDTH +: STRB_WIDTH] : '0;
    assign bram_addr   = bus.req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    assign bram_wrdata = bus.req_wrdata[gidx*DATA_WIDTH +: DATA_WIDTH];

    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;

    // latched means "response already presented once and not yet taken";
    // the BRAM output is captured exactly on the first unaccepted cycle.
    always_comb begin
        resp_valid_d = grant | (resp_valid_q & ~bus.resp_ready);
        latched_d    = resp_valid_q & ~bus.resp_ready;
        latch_load   = latched_d & ~latched_q;
    end

    always_comb begin
        bus.resp_rddata = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            bus.resp_rddata[i*DATA_WIDTH +: DATA_WIDTH] =
                latched_q[i] ? latch_data_q[i] : bram_rddata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_q <= '0;
            latched_q    <= '0;
            last_q       <= PTR_W'(NUM_PORTS - 1);
            for (int unsigned i = 0; i < NUM_PORTS; i++) latch_data_q[i] <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            latched_q    <= latched_d;
            if (found) last_q <= gidx;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (latch_load[i]) latch_data_q[i] <= bram_rddata;
            end
        end
    end
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter: two ports sharing a behavioural 64-bit BRAM.
module tb_bram_rr_arbiter;
    localparam int unsigned NP = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    bram_rr_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          bram_en;
    logic [7:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wrdata;
    logic [DW-1:0] bram_rddata;

    bram_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wrdata(bram_wrdata),
        .bram_rddata(bram_rddata)
    );

    // Read-first BRAM model with a bench-side preload port.
    logic [DW-1:0] mem [0:255];
    logic          pre_en;
    logic [7:0]    pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (bram_en) begin
            bram_rddata <= mem[bram_addr[7:0]];
            for (int b = 0; b < 8; b++) begin
                if (bram_we[b]) mem[bram_addr[7:0]][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
            end
        end
    end

    int errors;
    int checks;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [7:0] we,
                            input logic [15:0] addr, input logic [63:0] data);
        bus.req_valid[p]            = v;
        bus.req_we[p*8 +: 8]        = we;
        bus.req_addr[p*16 +: 16]    = addr;
        bus.req_wrdata[p*64 +: 64]  = data;
    endtask

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors         = 0;
        checks         = 0;
        rstn           = 1'b0;
        pre_en         = 1'b0;
        pre_addr       = '0;
        pre_data       = '0;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wrdata = '0;
        bus.resp_ready = '0;

        repeat (2) @(negedge clk);
        preload(8'h10, 64'hDEAD_BEEF_0000_0001);
        preload(8'h02, 64'h55);
        preload(8'h03, 64'hAA);
        preload(8'h05, 64'h0);
        #1;
        check("reset_resp_valid", 64'(bus.resp_valid), 64'(2'b00));
        check("reset_bram_en", 64'(bram_en), 64'(1'b0));

        @(negedge clk);
        rstn = 1'b1;

        // Single read
        @(negedge clk);
        set_port(0, 1'b1, 8'h00, 16'h0010, 64'h0);
        bus.resp_ready = 2'b11;
        #1;
        check("rd_req_ready", 64'(bus.req_ready), 64'(2'b01));
        check("rd_bram_en", 64'(bram_en), 64'(1'b1));
        check("rd_bram_we", 64'(bram_we), 64'(8'h00));
        check("rd_bram_addr", 64'(bram_addr), 64'(16'h0010));
        @(negedge clk);
        set_port(0, 1'b0, 8'h00, 16'h0, 64'h0);
        #1;
        check("rd_resp_valid", 64'(bus.resp_valid), 64'(2'b01));
        check("rd_resp_data", bus.resp_rddata[63:0], 64'hDEAD_BEEF_0000_0001);
        check("rd_bram_idle", 64'(bram_en), 64'(1'b0));
        @(negedge clk);
        #1;
        check("rd_resp_clear", 64'(bus.resp_valid), 64'(2'b00));

        // Contention from a fresh reset: grants alternate starting at port 0
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        set_port(0, 1'b1, 8'h00, 16'h0010, 64'h0);
        set_port(1, 1'b1, 8'h00, 16'h0010, 64'h0);
        #1;
        check("cont_g0", 64'(bus.req_ready), 64'(2'b01));
        @(negedge clk);
        #1;
        check("cont_g1", 64'(bus.req_ready), 64'(2'b10));
        check("cont_rv1", 64'(bus.resp_valid), 64'(2'b01));
        @(negedge clk);
        #1;
        check("cont_g2", 64'(bus.req_ready), 64'(2'b01));
        check("cont_rv2", 64'(bus.resp_valid), 64'(2'b10));
        @(negedge clk);
        #1;
        check("cont_g3", 64'(bus.req_ready), 64'(2'b10));
        check("cont_rv3", 64'(bus.resp_valid), 64'(2'b01));
        @(negedge clk);
        set_port(0, 1'b0, 8'h00, 16'h0, 64'h0);
        set_port(1, 1'b0, 8'h00, 16'h0, 64'h0);
        #1;
        check("cont_rv4", 64'(bus.resp_valid), 64'(2'b10));

        // Backpressure on port 1 while port 0 keeps working
        @(negedge clk);
        set_port(1, 1'b1, 8'h00, 16'h0002, 64'h0);
        bus.resp_ready = 2'b01;
        #1;
        check("bp_g1", 64'(bus.req_ready), 64'(2'b10));
        check("bp_addr1", 64'(bram_addr), 64'(16'h0002));
        @(negedge clk);
        set_port(0, 1'b1, 8'h00, 16'h0003, 64'h0);
        #1;
        check("bp_g0_only", 64'(bus.req_ready), 64'(2'b01));
        check("bp_addr0", 64'(bram_addr), 64'(16'h0003));
        check("bp_rv_a", 64'(bus.resp_valid), 64'(2'b10));
        check("bp_d1_a", bus.resp_rddata[127:64], 64'h55);
        @(negedge clk);
        set_port(0, 1'b0, 8'h00, 16'h0, 64'h0);
        #1;
        check("bp_rv_b", 64'(bus.resp_valid), 64'(2'b11));
        check("bp_d1_b", bus.resp_rddata[127:64], 64'h55);
        check("bp_d0", bus.resp_rddata[63:0], 64'hAA);
        check("bp_no_grant_b", 64'(bus.req_ready), 64'(2'b00));
        @(negedge clk);
        #1;
        check("bp_rv_c", 64'(bus.resp_valid), 64'(2'b10));
        check("bp_d1_c", bus.resp_rddata[127:64], 64'h55);
        check("bp_no_grant_c", 64'(bus.req_ready), 64'(2'b00));
        @(negedge clk);
        set_port(1, 1'b1, 8'h00, 16'h0010, 64'h0);
        bus.resp_ready = 2'b11;
        #1;
        check("bp_regrant", 64'(bus.req_ready), 64'(2'b10));
        check("bp_d1_d", bus.resp_rddata[127:64], 64'h55);
        @(negedge clk);
        set_port(1, 1'b0, 8'h00, 16'h0, 64'h0);
        #1;
        check("bp_rv_stay", 64'(bus.resp_valid), 64'(2'b10));
        check("bp_d1_new", bus.resp_rddata[127:64], 64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        #1;
        check("bp_rv_clear", 64'(bus.resp_valid), 64'(2'b00));

        // Partial write then read back
        @(negedge clk);
        set_port(0, 1'b1, 8'h0F, 16'h0005, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        check("pw_grant", 64'(bus.req_ready), 64'(2'b01));
        check("pw_we", 64'(bram_we), 64'(8'h0F));
        @(negedge clk);
        set_port(0, 1'b1, 8'h00, 16'h0005, 64'h0);
        #1;
        check("pw_wr_resp", 64'(bus.resp_valid), 64'(2'b01));
        check("pw_rd_grant", 64'(bus.req_ready), 64'(2'b01));
        @(negedge clk);
        set_port(0, 1'b0, 8'h00, 16'h0, 64'h0);
        #1;
        check("pw_rd_valid", 64'(bus.resp_valid), 64'(2'b01));
        check("pw_rd_data", bus.resp_rddata[63:0], 64'h0000_0000_FFFF_FFFF);

        // Streaming: 8 writes then 8 reads back-to-back on port 0
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_port(0, 1'b1, 8'hFF, 16'(i), 64'(i * 3));
            #1;
            check("st_wr_grant", 64'(bus.req_ready), 64'(2'b01));
            check("st_wr_addr", 64'(bram_addr), 64'(i));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_port(0, 1'b1, 8'h00, 16'(i), 64'h0);
            #1;
            check("st_rd_grant", 64'(bus.req_ready), 64'(2'b01));
            check("st_rv", 64'(bus.resp_valid), 64'(2'b01));
            if (i > 0) check("st_rd_data", bus.resp_rddata[63:0], 64'((i - 1) * 3));
        end
        @(negedge clk);
        set_port(0, 1'b0, 8'h00, 16'h0, 64'h0);
        #1;
        check("st_rd_last", bus.resp_rddata[63:0], 64'd21);

        // Reset while port 0 holds a latched response
        @(negedge clk);
        set_port(0, 1'b1, 8'h00, 16'h0010, 64'h0);
        bus.resp_ready = 2'b10;
        #1;
        check("rst_grant", 64'(bus.req_ready), 64'(2'b01));
        @(negedge clk);
        set_port(0, 1'b0, 8'h00, 16'h0, 64'h0);
        #1;
        check("rst_rv_a", 64'(bus.resp_valid), 64'(2'b01));
        @(negedge clk);
        #1;
        check("rst_rv_b", 64'(bus.resp_valid), 64'(2'b01));
        check("rst_latched", bus.resp_rddata[63:0], 64'hDEAD_BEEF_0000_0001);
        rstn = 1'b0;
        #1;
        check("rst_async_clear", 64'(bus.resp_valid), 64'(2'b00));
        set_port(0, 1'b1, 8'h00, 16'h0010, 64'h0);
        set_port(1, 1'b1, 8'h00, 16'h0010, 64'h0);
        bus.resp_ready = 2'b11;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_first_p0", 64'(bus.req_ready), 64'(2'b01));
        @(negedge clk);
        #1;
        check("rst_then_p1", 64'(bus.req_ready), 64'(2'b10));
        check("rst_rv_after", 64'(bus.resp_valid), 64'(2'b01));
        set_port(0, 1'b0, 8'h00, 16'h0, 64'h0);
        set_port(1, 1'b0, 8'h00, 16'h0, 64'h0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
